fb_arbiter: RTL and testbench

//  Shares one single-port frame RAM between the VGA scanout fetch (read) and the physics renderer (write).

---
 rtl/fb_pkg.sv | 10 +
 rtl/fb_clear_sweeper.sv | 37 +++
 rtl/fb_arbiter.sv | 106 ++++++++++
 tb/tb_fb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, pixel type and arbiter state encoding
package fb_pkg;
  localparam int FB_W = 400;
  localparam int FB_H = 300;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  typedef logic [DATA_W-1:0] pixel_t;
  typedef enum logic [1:0] {FB_IDLE, FB_CLEAR, FB_SWAP_WAIT} fb_state_e;
endpackage

// File: rtl/fb_clear_sweeper.sv
// fb_clear_sweeper: walks the back bank address by address, one word per granted slot
module fb_clear_sweeper #(
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W
) (
  input  logic              clock_162,
  input  logic              rst_n,
  input  logic              start,
  input  logic              slot,
  input  logic [DATA_W-1:0] color_in,
  output logic [ADDR_W-1:0] cnt,
  output logic [DATA_W-1:0] color,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  // counter restarts on start, advances on each granted slot and parks on the last word
  always_comb begin
    done = slot && cnt_q == LAST;
    cnt_d = start ? '0 : (slot && !done) ? cnt_q + 1'b1 : cnt_q;
    color_d = start ? color_in : color_q;
  end
  // sweep position and colour registers
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      color_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      color_q <= color_d;
    end
  end
  assign cnt = cnt_q;
  assign color = color_q;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame RAM arbitration between scanout, clear sweep and renderer with tear-free bank swap
module fb_arbiter #(
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock_162,
  input  logic              rst_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [ADDR_W-1:0] rnd_addr,
  input  logic [DATA_W-1:0] rnd_data,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  input  logic              swap_req,
  input  logic              frame_start,
  output logic              swap_done,
  output logic              front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import fb_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
  fb_state_e state_q, state_d;
  logic front_q, front_d, pend_q, pend_d, swap_done_q, swap_done_d;
  logic [RD_LAT-1:0] vld_q, vld_d, inr_q, inr_d;
  logic idle, slot, done, scan_in, wr_rnd;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] clr_col;
  assign idle = state_q == FB_IDLE;
  assign slot = state_q == FB_CLEAR && !scan_req;
  assign scan_in = scan_addr <= LAST;
  assign wr_rnd = !scan_req && idle && rnd_valid && rnd_addr <= LAST;
  fb_clear_sweeper #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sweep (
    .clock_162(clock_162),
    .rst_n(rst_n),
    .start(idle && clr_req),
    .slot(slot),
    .color_in(clr_color),
    .cnt(cnt),
    .color(clr_col),
    .done(done)
  );
  // swap FSM: a clear may carry a pending swap, and the bank only flips on frame_start
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    pend_d = pend_q;
    swap_done_d = 1'b0;
    if (idle && clr_req) begin
      state_d = FB_CLEAR;
      pend_d = swap_req;
    end else if (idle && swap_req) begin
      state_d = FB_SWAP_WAIT;
    end else if (state_q == FB_CLEAR) begin
      pend_d = done ? 1'b0 : pend_q || swap_req;
      state_d = !done ? FB_CLEAR : (pend_q || swap_req) ? FB_SWAP_WAIT : FB_IDLE;
    end else if (state_q == FB_SWAP_WAIT && frame_start) begin
      front_d = !front_q;
      swap_done_d = 1'b1;
      state_d = FB_IDLE;
    end
  end
  // one RAM access per cycle: scanout first, then the clear sweep, then the renderer
  always_comb begin
    mem_en = scan_req ? scan_in : slot || wr_rnd;
    mem_we = !scan_req && (slot || wr_rnd);
    mem_addr = scan_req ? {front_q, scan_addr} : slot ? {!front_q, cnt} : {!front_q, rnd_addr};
    mem_wdata = slot ? clr_col : rnd_data;
    vld_d = (vld_q << 1) | RD_LAT'(scan_req);
    inr_d = (inr_q << 1) | RD_LAT'(scan_req && scan_in);
  end
  // state, bank select and read-valid pipeline registers
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FB_IDLE;
      front_q <= 1'b0;
      pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      vld_q <= '0;
      inr_q <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      pend_q <= pend_d;
      swap_done_q <= swap_done_d;
      vld_q <= vld_d;
      inr_q <= inr_d;
    end
  end
  assign scan_rvalid = vld_q[RD_LAT-1];
  assign scan_rdata = (vld_q[RD_LAT-1] && inr_q[RD_LAT-1]) ? mem_rdata : '0;
  assign rnd_ready = !scan_req && idle;
  assign clr_busy = state_q == FB_CLEAR;
  assign swap_done = swap_done_q;
  assign front_bank = front_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed checks of arbitration, clear sweep, bank swap and reset behaviour
module tb_fb_arbiter;
  localparam int DEPTH = 1000;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int LAT = 2;
  logic clock_162 = 1'b0;
  logic rst_n = 1'b0;
  logic scan_req = 1'b0, rnd_valid = 1'b0, clr_req = 1'b0, swap_req = 1'b0, frame_start = 1'b0;
  logic [AW-1:0] scan_addr = '0, rnd_addr = '0;
  logic [DW-1:0] rnd_data = '0, clr_color = '0;
  logic scan_rvalid, rnd_ready, clr_busy, swap_done, front_bank, mem_en, mem_we;
  logic [DW-1:0] scan_rdata, mem_wdata, mem_rdata;
  logic [AW:0] mem_addr;
  logic [DW-1:0] mem [0:(1<<(AW+1))-1];
  logic [DW-1:0] rpipe [LAT];
  int n_chk = 0, n_fail = 0;
  int slots, bad0, bad1;
  fb_arbiter #(.FB_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clock_162(clock_162), .rst_n(rst_n),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_addr(rnd_addr), .rnd_data(rnd_data),
    .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
    .swap_req(swap_req), .frame_start(frame_start), .swap_done(swap_done), .front_bank(front_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clock_162 = ~clock_162;
  always @(posedge clock_162) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 12'hEEE;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];
  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 7 + 1);
  endfunction
  task automatic tick;
    @(posedge clock_162);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = pat(a);
      mem[(1 << AW) + a] = '0;
    end
    mem[5] = 12'hABC;
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    tick; tick;
    #1;
    chk("rst front_bank", 32'(front_bank), 0);
    chk("rst clr_busy", 32'(clr_busy), 0);
    chk("rst swap_done", 32'(swap_done), 0);
    chk("rst rvalid", 32'(scan_rvalid), 0);
    rst_n = 1'b1;
    tick;
    chk("idle rnd_ready", 32'(rnd_ready), 1);
    // scan read of bank 0, address 5
    scan_req = 1'b1; scan_addr = 17'd5;
    #1;
    chk("scan mem_addr", 32'(mem_addr), 32'h00005);
    chk("scan mem_en", 32'(mem_en), 1);
    chk("scan mem_we", 32'(mem_we), 0);
    tick;
    scan_req = 1'b0;
    #1;
    chk("scan rvalid early", 32'(scan_rvalid), 0);
    tick;
    chk("scan rvalid", 32'(scan_rvalid), 1);
    chk("scan rdata", 32'(scan_rdata), 32'hABC);
    tick;
    chk("scan rvalid drop", 32'(scan_rvalid), 0);
    // renderer blocked by scan, then accepted
    scan_req = 1'b1; scan_addr = 17'd9; rnd_valid = 1'b1; rnd_addr = 17'd7; rnd_data = 12'h123;
    #1;
    chk("rnd blocked ready", 32'(rnd_ready), 0);
    chk("rnd blocked we", 32'(mem_we), 0);
    tick;
    scan_req = 1'b0;
    #1;
    chk("rnd ready", 32'(rnd_ready), 1);
    chk("rnd mem_en", 32'(mem_en), 1);
    chk("rnd mem_we", 32'(mem_we), 1);
    chk("rnd mem_addr", 32'(mem_addr), 32'h20007);
    chk("rnd mem_wdata", 32'(mem_wdata), 32'h123);
    tick;
    chk("rnd written", 32'(mem[18'h20007]), 32'h123);
    rnd_addr = 17'(DEPTH);
    #1;
    chk("rnd oor ready", 32'(rnd_ready), 1);
    chk("rnd oor mem_en", 32'(mem_en), 0);
    tick;
    rnd_valid = 1'b0;
    tick; tick;
    // clear back bank 1 with scan contending every other cycle
    clr_req = 1'b1; clr_color = 12'hF00;
    tick;
    clr_req = 1'b0; clr_color = 12'h000;
    #1;
    chk("clr busy", 32'(clr_busy), 1);
    chk("clr rnd_ready", 32'(rnd_ready), 0);
    slots = 0;
    for (int i = 0; i < 5000; i++) begin
      scan_req = i[0]; scan_addr = 17'd0;
      #1;
      if (!clr_busy) break;
      if (mem_en && mem_we) slots++;
      tick;
    end
    scan_req = 1'b0;
    chk("clr done busy", 32'(clr_busy), 0);
    chk("clr slots", 32'(slots), 32'(DEPTH));
    bad0 = 0; bad1 = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[(1 << AW) + a] !== 12'hF00) bad1++;
      if (mem[a] !== ((a == 5) ? 12'hABC : pat(a))) bad0++;
    end
    chk("clr back bank words", 32'(bad1), 0);
    chk("clr front untouched", 32'(bad0), 0);
    // swap request, frame_start ten cycles later
    tick;
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    frame_start = 1'b1; scan_req = 1'b1; scan_addr = 17'd3;
    #1;
    chk("swap old bank read", 32'(mem_addr), 32'h00003);
    chk("swap front before", 32'(front_bank), 0);
    tick;
    frame_start = 1'b0; scan_req = 1'b0;
    #1;
    chk("swap front after", 32'(front_bank), 1);
    chk("swap_done pulse", 32'(swap_done), 1);
    tick;
    chk("swap_done once", 32'(swap_done), 0);
    scan_req = 1'b1; scan_addr = 17'd5;
    #1;
    chk("swap new bank addr", 32'(mem_addr), 32'h20005);
    tick;
    scan_req = 1'b0;
    tick;
    chk("swap new bank rdata", 32'(scan_rdata), 32'hF00);
    tick;
    // swap_req with frame_start in the same cycle is not honoured
    swap_req = 1'b1; frame_start = 1'b1;
    tick;
    swap_req = 1'b0; frame_start = 1'b0;
    #1;
    chk("same-cycle no swap", 32'(front_bank), 1);
    chk("same-cycle no done", 32'(swap_done), 0);
    tick; tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    #1;
    chk("second fs swap", 32'(front_bank), 0);
    chk("second fs done", 32'(swap_done), 1);
    tick;
    // clear plus swap together: swap only once the clear has finished
    clr_req = 1'b1; swap_req = 1'b1; clr_color = 12'h0F0;
    tick;
    clr_req = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      frame_start = (i == 10);
      #1;
      if (!clr_busy) break;
      tick;
    end
    frame_start = 1'b0;
    chk("clr+swap busy end", 32'(clr_busy), 0);
    chk("clr+swap no early swap", 32'(front_bank), 0);
    chk("clr+swap waiting ready", 32'(rnd_ready), 0);
    chk("clr+swap colour", 32'(mem[(1 << AW) + DEPTH - 1]), 32'h0F0);
    tick; tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    #1;
    chk("clr+swap swapped", 32'(front_bank), 1);
    chk("clr+swap done", 32'(swap_done), 1);
    tick;
    // reset in the middle of a clear of bank 0
    clr_req = 1'b1; clr_color = 12'h00F;
    tick;
    clr_req = 1'b0;
    for (int i = 0; i < 500; i++) tick;
    scan_req = 1'b1; scan_addr = 17'd1;
    #1;
    chk("mid-clear busy", 32'(clr_busy), 1);
    chk("mid-clear scan addr", 32'(mem_addr), 32'h20001);
    tick;
    rst_n = 1'b0; scan_req = 1'b0;
    #1;
    chk("mid rst busy", 32'(clr_busy), 0);
    chk("mid rst front", 32'(front_bank), 0);
    chk("mid rst rvalid", 32'(scan_rvalid), 0);
    tick;
    chk("mid rst rvalid held", 32'(scan_rvalid), 0);
    chk("mid rst last write", 32'(mem[499]), 32'h00F);
    chk("mid rst no extra write", 32'(mem[500]), 32'(pat(500)));
    rst_n = 1'b1;
    tick;
    chk("post rst ready", 32'(rnd_ready), 1);
    // scan beyond the bank: no RAM access, zero data
    scan_req = 1'b1; scan_addr = 17'(DEPTH);
    #1;
    chk("oor scan mem_en", 32'(mem_en), 0);
    tick;
    scan_req = 1'b0;
    tick;
    chk("oor scan rvalid", 32'(scan_rvalid), 1);
    chk("oor scan rdata", 32'(scan_rdata), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
